// File: rtl/mp_addsub_seq_pkg.sv
// mp_addsub_pkg: shared FSM state encoding and add/sub mode constants for mp_addsub_seq
package mp_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/mp_addsub_seq_if.sv
// mp_addsub_seq_if: operand/result stream and flag bundle of the multi-precision add/sub sequencer
//   master: start, mode, in_valid, in_a, in_b, in_last, out_ready
//   slave : in_ready, out_valid, out_sum, out_last, done, carry, ovf, zero, err
interface mp_addsub_seq_if #(parameter int N = 8);
    logic         start, mode;
    logic         in_valid, in_ready, in_last;
    logic [N-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_last;
    logic [N-1:0] out_sum;
    logic         done, carry, ovf, zero, err;
    modport master (
        output start, mode, in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_last, done, carry, ovf, zero, err
    );
    modport slave (
        input  start, mode, in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_last, done, carry, ovf, zero, err
    );
endinterface

// File: rtl/mp_addsub_seq_addsub.sv
// addSub: N-bit add/subtract slice
//   a, b, cin, mode(0 add / 1 sub) in; sum, cout (add carry), borrow (sub borrow) out
module addSub #(parameter int N = 8) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         mode,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         borrow
);
    logic [N:0] add_r, sub_r;
    assign add_r  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    // a-b-cin never drops below -2^N, so bit N flags a negative result, i.e. a < b+cin
    assign sub_r  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
    assign sum    = mode ? sub_r[N-1:0] : add_r[N-1:0];
    assign cout   = add_r[N];
    assign borrow = sub_r[N];
endmodule

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq: multi-precision add/sub sequencer streaming K words LSB first through one addSub slice
//   clk, rst_n (async active-low); bus: mp_addsub_seq_if.slave (operand in, result out, final flags)
//   MPAS_LEN_CHECK_EN: bounds operands to MAX_WORDS words, forcing the last word and raising err
module mp_addsub_seq
    import mp_addsub_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_WORDS = 16
) (
    input logic             clk,
    input logic             rst_n,
    mp_addsub_seq_if.slave  bus
);
    if (MAX_WORDS < 1) begin : g_bad_max_words
        $error("MAX_WORDS must be at least 1");
    end
    state_t       state, state_nx;
    logic         mode_q, chain, zacc;
    logic [N-1:0] s;
    logic         cout, borrow, c_word, accept, last_in, fin;
    addSub #(.N(N)) u_core (
        .a      (bus.in_a),
        .b      (bus.in_b),
        .cin    (chain),
        .mode   (mode_q),
        .sum    (s),
        .cout   (cout),
        .borrow (borrow)
    );
    // a stalled result blocks new input, so out_sum stays put while out_ready is low
    assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign fin          = (state == DRAIN) && bus.out_valid && bus.out_ready;
    assign c_word       = (mode_q == MODE_SUB) ? borrow : cout;
`ifdef MPAS_LEN_CHECK_EN
    localparam int CW = $clog2(MAX_WORDS + 1);
    logic [CW-1:0] cnt;
    logic          forced, err_p;
    assign forced  = (cnt == CW'(MAX_WORDS - 1)) && !bus.in_last;
    assign last_in = bus.in_last || forced;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            err_p   <= 1'b0;
            bus.err <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            cnt     <= '0;
            err_p   <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            if (accept) cnt <= cnt + 1'b1;
            if (accept && forced) err_p <= 1'b1;
            if (fin) bus.err <= err_p;
        end
    end
`else
    assign last_in = bus.in_last;
    assign bus.err = 1'b0;
`endif
    always_comb begin
        state_nx = (state == IDLE && bus.start)           ? RUN   :
                   (state == RUN && accept && last_in)    ? DRAIN :
                   fin                                    ? IDLE  : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_ADD;
            chain         <= 1'b0;
            zacc          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
        end else begin
            bus.done <= fin;
            if (state == IDLE && bus.start) begin
                mode_q <= bus.mode;
                chain  <= 1'b0;
                zacc   <= 1'b1;
            end
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_sum   <= s;
                bus.out_last  <= last_in;
                chain         <= c_word;
                zacc          <= zacc && (s == '0);
                if (last_in) begin
                    bus.carry <= c_word;
                    bus.ovf   <= ((mode_q == MODE_SUB) ? (bus.in_a[N-1] != bus.in_b[N-1])
                                                       : (bus.in_a[N-1] == bus.in_b[N-1]))
                                 && (s[N-1] != bus.in_a[N-1]);
                    bus.zero  <= zacc && (s == '0);
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mp_addsub_seq.sv
// tb_mp_addsub_seq: directed self-checking bench for mp_addsub_seq (N=8)
module tb_mp_addsub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    mp_addsub_seq_if #(.N(8)) bus ();
    mp_addsub_seq #(.N(8), .MAX_WORDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic run_op(input string name, input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input int k, input logic ec, input logic eo, input logic ez);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < k; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = a[8*i +: 8];
            bus.in_b     = b[8*i +: 8];
            bus.in_last  = (i == k - 1);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_last, bus.out_sum} !== {1'b1, i == k - 1, r[8*i +: 8]}) begin
                errs++;
                $display("FAIL %s word%0d: got v/l/sum=%b/%b/%h exp 1/%b/%h", name, i,
                         bus.out_valid, bus.out_last, bus.out_sum, i == k - 1, r[8*i +: 8]);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.out_valid, bus.carry, bus.ovf, bus.zero, bus.err} !== {1'b1, 1'b0, ec, eo, ez, 1'b0}) begin
            errs++;
            $display("FAIL %s flags: got done/v/c/o/z/e=%b%b%b%b%b%b exp 10%b%b%b0", name,
                     bus.done, bus.out_valid, bus.carry, bus.ovf, bus.zero, bus.err, ec, eo, ez);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.carry, bus.ovf, bus.zero} !== {1'b0, ec, eo, ez}) begin
            errs++;
            $display("FAIL %s hold: got done/c/o/z=%b%b%b%b exp 0%b%b%b", name,
                     bus.done, bus.carry, bus.ovf, bus.zero, ec, eo, ez);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.mode = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
        bus.in_last = 0; bus.out_ready = 1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_last, bus.done, bus.carry, bus.ovf, bus.zero, bus.err, bus.out_sum} !== 16'h0) begin
            errs++;
            $display("FAIL reset_outputs: got %b exp all 0", {bus.in_ready, bus.out_valid, bus.out_last,
                     bus.done, bus.carry, bus.ovf, bus.zero, bus.err, bus.out_sum});
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a = 8'h55;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            errs++;
            $display("FAIL idle_in_valid: got ready/valid=%b%b exp 00", bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_add();
        run_op("add_12c8_0046", 1'b0, 32'h12C8, 32'h0046, 32'h130E, 2, 1'b0, 1'b0, 1'b0);
        run_op("add_7fff_0001", 1'b0, 32'h7FFF, 32'h0001, 32'h8000, 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_0100_0001", 1'b1, 32'h0100, 32'h0001, 32'h00FF, 2, 1'b0, 1'b0, 1'b0);
        run_op("sub_1234_1234", 1'b1, 32'h1234, 32'h1234, 32'h0000, 2, 1'b0, 1'b0, 1'b1);
        run_op("sub_0000_0001", 1'b1, 32'h0000, 32'h0001, 32'hFFFF, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_single_word();
        run_op("single_80_80", 1'b0, 32'h80, 32'h80, 32'h00, 1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 1'b0, 32'h00FFFF, 32'h000001, 32'h010000, 3, 1'b0, 1'b0, 1'b0);
        run_op("b2b_second", 1'b1, 32'h0001, 32'h0002, 32'hFFFF, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'h80; bus.in_b = 8'h90; bus.in_last = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_a = 8'hFF; bus.in_b = 8'h00;
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.out_sum} !== {1'b0, 1'b1, 8'h10}) begin
                errs++;
                $display("FAIL stall%0d: got ready/v/sum=%b/%b/%h exp 0/1/10", j, bus.in_ready, bus.out_valid, bus.out_sum);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_sum} !== {1'b1, 1'b0, 8'h00}) begin
            errs++;
            $display("FAIL bp_word1: got v/l/sum=%b/%b/%h exp 1/0/00", bus.out_valid, bus.out_last, bus.out_sum);
        end
        bus.in_a = 8'h10; bus.in_b = 8'h20; bus.in_last = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_sum} !== {1'b1, 1'b1, 8'h31}) begin
            errs++;
            $display("FAIL bp_word2: got v/l/sum=%b/%b/%h exp 1/1/31", bus.out_valid, bus.out_last, bus.out_sum);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.carry, bus.ovf, bus.zero} !== 4'b1000) begin
            errs++;
            $display("FAIL bp_flags: got done/c/o/z=%b%b%b%b exp 1000", bus.done, bus.carry, bus.ovf, bus.zero);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'h01; bus.in_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.done, bus.carry, bus.ovf, bus.zero, bus.out_sum} !== 14'h0) begin
            errs++;
            $display("FAIL reset_mid_op: got %b exp all 0", {bus.in_ready, bus.out_valid, bus.done,
                     bus.carry, bus.ovf, bus.zero, bus.out_sum});
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_done: got done=%b exp 0", bus.done);
        end
        rst_n = 1'b1;
        run_op("after_reset", 1'b0, 32'h0000, 32'h0000, 32'h0000, 2, 1'b0, 1'b0, 1'b1);
    endtask

`ifdef MPAS_LEN_CHECK_EN
    task automatic test_len_check();
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 8'(i + 1); bus.in_b = 8'h00; bus.in_last = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_last, bus.out_sum} !== {1'b1, i == 15, 8'(i + 1)}) begin
                errs++;
                $display("FAIL len_word%0d: got v/l/sum=%b/%b/%h exp 1/%b/%h", i, bus.out_valid,
                         bus.out_last, bus.out_sum, i == 15, 8'(i + 1));
            end
        end
        bus.in_a = 8'h11;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errs++;
            $display("FAIL len_word17_ready: got %b exp 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.err, bus.out_valid} !== 3'b110) begin
            errs++;
            $display("FAIL len_err: got done/err/v=%b%b%b exp 110", bus.done, bus.err, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.done, bus.err, bus.out_valid} !== 3'b010) begin
            errs++;
            $display("FAIL len_err_hold: got done/err/v=%b%b%b exp 010", bus.done, bus.err, bus.out_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
`ifdef MPAS_LEN_CHECK_EN
        test_len_check();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
